a_mux_sel_ctrl: RTL and testbench

A_MUX_SEL_CTRL -- requirements
Module: a_mux_sel_ctrl

---
 rtl/a_mux_sel_ctrl_pkg.sv | 10 +
 rtl/a_mux_sel_ctrl.sv | 92 +++++++++
 tb/tb_a_mux_sel_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/a_mux_sel_ctrl_pkg.sv
// LDPC_pkg: shared LDPC encoder constants and the A-mux select controller state type.
package LDPC_pkg;
  localparam int MAX_ZC = 384;
  localparam int BG1_ROWS = 46;
  localparam int BG1_COLS = 68;
  localparam int BG2_ROWS = 42;
  localparam int BG2_COLS = 52;
  localparam int DEF_CORE_PARITY_COUNT = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} a_ctrl_state_t;
endpackage

// File: rtl/a_mux_sel_ctrl.sv
// a_mux_sel_ctrl: steers the A-mux select bus while core parity blocks are written after kb message blocks.
module a_mux_sel_ctrl
  import LDPC_pkg::*;
#(
  parameter int MUXES_COUNT = 23,
  parameter int CORE_PARITY_COUNT = DEF_CORE_PARITY_COUNT,
  localparam int IDX_W = $clog2(MUXES_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [IDX_W-1:0]       kb,
  input  logic                   abort,
  input  logic                   parity_valid,
  input  logic [IDX_W-1:0]       parity_idx,
  output logic                   step_req,
  output logic [IDX_W-1:0]       step_idx,
  output logic [MUXES_COUNT-1:0] select_lines,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam logic [IDX_W:0] CPC_W = (IDX_W+1)'(CORE_PARITY_COUNT);
  localparam logic [IDX_W:0] MUX_W = (IDX_W+1)'(MUXES_COUNT);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(CORE_PARITY_COUNT - 1);
  a_ctrl_state_t state_q, state_d;
  logic [MUXES_COUNT-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] k_q, k_d, kb_q, kb_d;
  logic err_q, err_d;
  logic [IDX_W:0] pos, kb_w;
  logic kb_bad, hit;
  // one extra bit so kb+k and the range check can never wrap
  assign pos = {1'b0, kb_q} + {1'b0, k_q};
  assign kb_w = {1'b0, kb};
  assign kb_bad = (kb_w == '0) || (kb_w + CPC_W > MUX_W);
  assign hit = {1'b0, parity_idx} == pos;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    k_d = k_q;
    kb_d = kb_q;
    err_d = err_q;
    if (abort) begin
      state_d = IDLE;
      sel_d = '0;
      k_d = '0;
    end else if ((state_q == IDLE || state_q == ERR) && start) begin
      if (kb_bad) begin
        state_d = ERR;
        err_d = 1'b1;
      end else begin
        state_d = RUN;
        kb_d = kb;
        sel_d = '0;
        k_d = '0;
        err_d = 1'b0;
      end
    end else if (state_q == RUN && parity_valid) begin
      if (hit) begin
        sel_d[pos[IDX_W-1:0]] = 1'b1;
        k_d = k_q + IDX_W'(1);
        state_d = (k_q == K_LAST) ? DONE : RUN;
      end else begin
        state_d = ERR;
        err_d = 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      k_q <= '0;
      kb_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      k_q <= k_d;
      kb_q <= kb_d;
      err_q <= err_d;
    end
  end
  assign step_req = state_q == RUN;
  assign step_idx = step_req ? pos[IDX_W-1:0] : '0;
  assign select_lines = sel_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
endmodule

// File: tb/tb_a_mux_sel_ctrl.sv
// tb_a_mux_sel_ctrl: table-driven and hand-sequenced checks of the A-mux select controller via an expected-output queue.
module tb_a_mux_sel_ctrl;
  localparam int N = 23;
  localparam int W = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic parity_valid = 1'b0;
  logic [W-1:0] kb = '0;
  logic [W-1:0] parity_idx = '0;
  logic step_req, busy, done, err;
  logic [W-1:0] step_idx;
  logic [N-1:0] select_lines;
  always #5 clk = ~clk;
  a_mux_sel_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kb(kb), .abort(abort),
    .parity_valid(parity_valid), .parity_idx(parity_idx), .step_req(step_req),
    .step_idx(step_idx), .select_lines(select_lines), .busy(busy), .done(done), .err(err)
  );
  typedef struct packed {logic s; logic [W-1:0] k; logic a; logic v; logic [W-1:0] p;} in_t;
  typedef struct packed {logic req; logic [W-1:0] idx; logic [N-1:0] sel; logic busy; logic done; logic err;} out_t;
  typedef struct {in_t i; out_t o; string nm;} vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  int checks = 0;
  int passed = 0;
  out_t act;
  assign act = {step_req, step_idx, select_lines, busy, done, err};
  function automatic in_t ii(bit s, int k, bit a, bit v, int p);
    return {s, W'(k), a, v, W'(p)};
  endfunction
  function automatic out_t oo(bit r, int x, int s, bit b, bit d, bit e);
    return {r, W'(x), N'(s), b, d, e};
  endfunction
  task automatic check(string nm, out_t a, out_t e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got req=%0b idx=%0d sel=%06h busy=%0b done=%0b err=%0b; want req=%0b idx=%0d sel=%06h busy=%0b done=%0b err=%0b",
      nm, a.req, a.idx, a.sel, a.busy, a.done, a.err, e.req, e.idx, e.sel, e.busy, e.done, e.err);
  endtask
  task automatic drive(in_t x, out_t e, string nm);
    {start, kb, abort, parity_valid, parity_idx} = x;
    @(posedge clk);
    #1;
    sb.push_back('{x, e, nm});
  endtask
  task automatic add(in_t x, out_t e, string nm);
    tbl.push_back('{x, e, nm});
  endtask
  always @(negedge clk) begin
    vec_t v;
    if (sb.size() > 0) begin
      v = sb.pop_front();
      check(v.nm, act, v.o);
    end
  end
  initial begin
    int sel;
    #12;
    check("reset_state", act, '0);
    rst_n = 1'b1;
    add(ii(1, 10, 0, 0, 0), oo(1, 10, 0, 1, 0, 0), "nom_start");
    add(ii(0, 0, 0, 1, 10), oo(1, 11, 'h400, 1, 0, 0), "nom_acc10");
    add(ii(0, 0, 0, 1, 11), oo(1, 12, 'hC00, 1, 0, 0), "nom_acc11");
    add(ii(0, 0, 0, 1, 12), oo(1, 13, 'h1C00, 1, 0, 0), "nom_acc12");
    add(ii(0, 0, 0, 1, 13), oo(0, 0, 'h3C00, 1, 1, 0), "nom_done");
    add(ii(0, 0, 0, 0, 0), oo(0, 0, 'h3C00, 0, 0, 0), "nom_idle_hold");
    add(ii(0, 0, 0, 1, 3), oo(0, 0, 'h3C00, 0, 0, 0), "idle_pv_ignored");
    add(ii(0, 0, 1, 0, 0), oo(0, 0, 0, 0, 0, 0), "abort_clears");
    add(ii(1, 20, 0, 0, 0), oo(0, 0, 0, 1, 0, 1), "kb20_err");
    add(ii(0, 0, 0, 0, 0), oo(0, 0, 0, 1, 0, 1), "err_hold");
    add(ii(1, 0, 0, 0, 0), oo(0, 0, 0, 1, 0, 1), "kb0_err");
    add(ii(0, 0, 1, 0, 0), oo(0, 0, 0, 0, 0, 1), "abort_keeps_err");
    add(ii(1, 5, 0, 0, 0), oo(1, 5, 0, 1, 0, 0), "mm_start");
    add(ii(0, 0, 0, 1, 5), oo(1, 6, 'h20, 1, 0, 0), "mm_acc5");
    add(ii(0, 0, 0, 1, 8), oo(0, 0, 'h20, 1, 0, 1), "mm_err_sel_hold");
    add(ii(0, 0, 0, 1, 6), oo(0, 0, 'h20, 1, 0, 1), "err_pv_ignored");
    add(ii(1, 5, 0, 0, 0), oo(1, 5, 0, 1, 0, 0), "err_restart");
    add(ii(0, 0, 0, 1, 7), oo(0, 0, 0, 1, 0, 1), "mm_idx7");
    add(ii(1, 1, 0, 0, 0), oo(1, 1, 0, 1, 0, 0), "col_start");
    add(ii(0, 0, 0, 1, 1), oo(1, 2, 'h2, 1, 0, 0), "col_acc1");
    add(ii(1, 9, 0, 1, 2), oo(1, 3, 'h6, 1, 0, 0), "run_start_ignored");
    add(ii(0, 0, 0, 1, 3), oo(1, 4, 'hE, 1, 0, 0), "col_acc3");
    add(ii(1, 9, 1, 1, 4), oo(0, 0, 0, 0, 0, 0), "abort_collision");
    add(ii(0, 0, 0, 0, 0), oo(0, 0, 0, 0, 0, 0), "no_done_after_abort");
    add(ii(1, 1, 0, 0, 0), oo(1, 1, 0, 1, 0, 0), "k1_start");
    add(ii(0, 0, 0, 1, 1), oo(1, 2, 'h2, 1, 0, 0), "k1_acc1");
    add(ii(0, 0, 0, 1, 2), oo(1, 3, 'h6, 1, 0, 0), "k1_acc2");
    add(ii(0, 0, 0, 1, 3), oo(1, 4, 'hE, 1, 0, 0), "k1_acc3");
    add(ii(0, 0, 0, 1, 4), oo(0, 0, 'h1E, 1, 1, 0), "k1_done");
    add(ii(1, 2, 0, 0, 0), oo(0, 0, 'h1E, 0, 0, 0), "done_start_ignored");
    foreach (tbl[n]) drive(tbl[n].i, tbl[n].o, tbl[n].nm);
    drive(ii(1, 19, 0, 0, 0), oo(1, 19, 0, 1, 0, 0), "bp_start");
    sel = 0;
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 5; c++) drive(ii(0, 0, 0, 0, 0), oo(1, 19 + b, sel, 1, 0, 0), "bp_stall");
      sel = sel | (1 << (19 + b));
      if (b < 3) drive(ii(0, 0, 0, 1, 19 + b), oo(1, 20 + b, sel, 1, 0, 0), "bp_acc");
      else drive(ii(0, 0, 0, 1, 22), oo(0, 0, 'h780000, 1, 1, 0), "bp_done");
    end
    drive(ii(0, 0, 0, 0, 0), oo(0, 0, 'h780000, 0, 0, 0), "bp_idle");
    drive(ii(1, 7, 0, 0, 0), oo(1, 7, 0, 1, 0, 0), "rst_run_start");
    drive(ii(0, 0, 0, 1, 7), oo(1, 8, 'h80, 1, 0, 0), "rst_run_acc7");
    drive(ii(0, 0, 0, 1, 8), oo(1, 9, 'h180, 1, 0, 0), "rst_run_acc8");
    {start, kb, abort, parity_valid, parity_idx} = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", act, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(ii(1, 3, 0, 0, 0), oo(1, 3, 0, 1, 0, 0), "post_rst_start");
    drive(ii(0, 0, 0, 1, 3), oo(1, 4, 'h8, 1, 0, 0), "post_rst_acc3");
    drive(ii(0, 0, 0, 1, 4), oo(1, 5, 'h18, 1, 0, 0), "post_rst_acc4");
    drive(ii(0, 0, 0, 1, 5), oo(1, 6, 'h38, 1, 0, 0), "post_rst_acc5");
    drive(ii(0, 0, 0, 1, 6), oo(0, 0, 'h78, 1, 1, 0), "post_rst_done");
    drive(ii(0, 0, 0, 0, 0), oo(0, 0, 'h78, 0, 0, 0), "post_rst_idle");
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
